// File: rtl/shift_unit_seq.sv
// shift_unit_seq
//   Multi-cycle shift/rotate unit for the datapath ALU. Shifts operand A
//   (from Y) by the amount in operand B (from the bus) at up to STEP bit
//   positions per cycle. The control sequencer stalls its T-step on `done`
//   and then loads `result` into Z low.
//
// Parameters
//   WIDTH  operand/result width (power of two, >= 8)
//   STEP   max bit positions shifted per cycle (power of two, 1..WIDTH)
//   SHW    shift-amount width, derived from WIDTH
//
// Ports
//   clock   rising-edge clock
//   clear   synchronous active-high reset; aborts any operation
//   start   request, honoured only in IDLE or DONE
//   mode    000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, others pass-through
//   a       value to shift
//   b       shift amount; only b[SHW-1:0] is used
//   result  registered result, updated on entry to DONE
//   busy    high while shifting
//   done    one-cycle pulse per completed operation
//   cout    last bit shifted/rotated out (0 for a zero amount or pass-through)

module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [2:0] MODE_SHL  = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHRA = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;

  // One bit wider than an amount so that STEP == WIDTH is representable.
  localparam logic [SHW:0]       STEP_W = (SHW + 1)'(STEP);
  localparam logic [WIDTH-1:0]   ONES   = '1;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [2:0]       mode_q;
  logic [SHW-1:0]   rem;
  logic             sign_q;

  logic [SHW-1:0]   n_in;
  logic [SHW-1:0]   k;
  logic [SHW-1:0]   k_left_idx;
  logic [SHW-1:0]   k_right_idx;
  logic [WIDTH-1:0] step_val;
  logic             step_cout;
  logic             pass_mode;
  logic             unused_b_hi;

  assign unused_b_hi = ^b[WIDTH-1:SHW];

  always_comb begin
    n_in      = b[SHW-1:0];
    pass_mode = (mode > MODE_ROR);

    if ({1'b0, rem} < STEP_W) begin
      k = rem;
    end else begin
      k = STEP_W[SHW-1:0];
    end

    // Modulo-WIDTH arithmetic: '0 - k equals WIDTH - k because WIDTH = 2**SHW.
    k_left_idx  = '0 - k;
    k_right_idx = k - SHW'(1);

    step_val  = work;
    step_cout = 1'b0;
    case (mode_q)
      MODE_SHL: begin
        step_val  = work << k;
        step_cout = work[k_left_idx];
      end
      MODE_SHR: begin
        step_val  = work >> k;
        step_cout = work[k_right_idx];
      end
      MODE_SHRA: begin
        step_val  = (work >> k) | ({WIDTH{sign_q}} & ~(ONES >> k));
        step_cout = work[k_right_idx];
      end
      MODE_ROL: begin
        step_val  = (work << k) | (work >> k_left_idx);
        step_cout = work[k_left_idx];
      end
      MODE_ROR: begin
        step_val  = (work >> k) | (work << k_left_idx);
        step_cout = work[k_right_idx];
      end
      default: begin
        step_val  = work;
        step_cout = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      work   <= '0;
      mode_q <= '0;
      rem    <= '0;
      sign_q <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work   <= a;
            mode_q <= mode;
            rem    <= n_in;
            sign_q <= a[WIDTH-1];
            if ((n_in == '0) || pass_mode) begin
              state  <= DONE;
              result <= a;
              cout   <= 1'b0;
            end else begin
              state <= SHIFT;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= step_val;
          rem  <= rem - k;
          if (rem == k) begin
            state  <= DONE;
            result <= step_val;
            cout   <= step_cout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
module tb_shift_unit_seq;

  localparam logic [2:0] SHL  = 3'b000;
  localparam logic [2:0] SHR  = 3'b001;
  localparam logic [2:0] SHRA = 3'b010;
  localparam logic [2:0] ROL  = 3'b011;
  localparam logic [2:0] ROR  = 3'b100;
  localparam logic [2:0] PASS = 3'b111;

  logic        clock = 1'b0;
  logic        clear;
  logic        start1, start4;
  logic [2:0]  mode;
  logic [31:0] a, b;
  logic [31:0] res1, res4;
  logic        busy1, busy4, done1, done4, cout1, cout4;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  shift_unit_seq #(.WIDTH(32), .STEP(1)) dut1 (
    .clock(clock), .clear(clear), .start(start1), .mode(mode), .a(a), .b(b),
    .result(res1), .busy(busy1), .done(done1), .cout(cout1)
  );

  shift_unit_seq #(.WIDTH(32), .STEP(4)) dut4 (
    .clock(clock), .clear(clear), .start(start4), .mode(mode), .a(a), .b(b),
    .result(res4), .busy(busy4), .done(done4), .cout(cout4)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one start pulse (edge E0), then scrambles the operands.
  task automatic issue(input int sel, input logic [2:0] m,
                       input logic [31:0] av, input logic [31:0] bv);
    mode = m; a = av; b = bv;
    if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
    mode = ROR; a = 32'hDEADBEEF; b = 32'h5;
  endtask

  // Observes cycles 1.. after E0 until done; lat = index of the done cycle.
  task automatic wait_done(input int sel, output int busy_n, output int lat,
                           output int overlap);
    busy_n = 0; lat = 0; overlap = 0;
    for (int i = 1; i <= 100; i++) begin
      logic bz, dn;
      bz = (sel == 4) ? busy4 : busy1;
      dn = (sel == 4) ? done4 : done1;
      if (bz) busy_n++;
      if (bz && dn) overlap++;
      if (dn) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick(); tick();
    vectors++; if (res1 !== 32'h0) begin errors++; $display("FAIL reset_res1: got %h want %h", res1, 32'h0); end
    vectors++; if ({busy1, done1, cout1} !== 3'b000) begin errors++; $display("FAIL reset_flags1: got %b want 000", {busy1, done1, cout1}); end
    vectors++; if ({res4, busy4, done4, cout4} !== 35'h0) begin errors++; $display("FAIL reset_dut4: got %h want 0", {res4, busy4, done4, cout4}); end
    clear = 1'b0;
    tick();
  endtask

  task automatic test_shl();
    int bn, lat, ov;
    issue(1, SHL, 32'hFFFFFFFF, 32'd2);
    wait_done(1, bn, lat, ov);
    vectors++; if (bn !== 2) begin errors++; $display("FAIL shl_busy: got %0d want 2", bn); end
    vectors++; if (lat !== 3) begin errors++; $display("FAIL shl_latency: got %0d want 3", lat); end
    vectors++; if (res1 !== 32'hFFFFFFFC) begin errors++; $display("FAIL shl_result: got %h want FFFFFFFC", res1); end
    vectors++; if (cout1 !== 1'b1) begin errors++; $display("FAIL shl_cout: got %b want 1", cout1); end
    vectors++; if (ov !== 0) begin errors++; $display("FAIL shl_overlap: got %0d want 0", ov); end
    tick();
  endtask

  task automatic test_right_step4();
    int bn, lat, ov;
    issue(4, SHRA, 32'h80000000, 32'd31);
    wait_done(4, bn, lat, ov);
    vectors++; if (bn !== 8) begin errors++; $display("FAIL shra4_busy: got %0d want 8", bn); end
    vectors++; if (lat !== 9) begin errors++; $display("FAIL shra4_latency: got %0d want 9", lat); end
    vectors++; if (res4 !== 32'hFFFFFFFF) begin errors++; $display("FAIL shra4_result: got %h want FFFFFFFF", res4); end
    vectors++; if (cout4 !== 1'b0) begin errors++; $display("FAIL shra4_cout: got %b want 0", cout4); end
    tick();
    issue(4, SHR, 32'h80000000, 32'd31);
    wait_done(4, bn, lat, ov);
    vectors++; if (bn !== 8) begin errors++; $display("FAIL shr4_busy: got %0d want 8", bn); end
    vectors++; if (res4 !== 32'h00000001) begin errors++; $display("FAIL shr4_result: got %h want 00000001", res4); end
    vectors++; if (cout4 !== 1'b0) begin errors++; $display("FAIL shr4_cout: got %b want 0", cout4); end
    tick();
    // Maximum amount at one bit per cycle.
    issue(1, SHR, 32'h80000000, 32'd31);
    wait_done(1, bn, lat, ov);
    vectors++; if (lat !== 32) begin errors++; $display("FAIL shr1_n31_latency: got %0d want 32", lat); end
    vectors++; if (res1 !== 32'h00000001) begin errors++; $display("FAIL shr1_n31_result: got %h want 00000001", res1); end
    tick();
  endtask

  task automatic test_rotate();
    int bn, lat, ov;
    issue(1, ROR, 32'h0000000F, 32'd4);
    wait_done(1, bn, lat, ov);
    vectors++; if (lat !== 5) begin errors++; $display("FAIL ror_latency: got %0d want 5", lat); end
    vectors++; if (res1 !== 32'hF0000000) begin errors++; $display("FAIL ror_result: got %h want F0000000", res1); end
    vectors++; if (cout1 !== 1'b1) begin errors++; $display("FAIL ror_cout: got %b want 1", cout1); end
    tick();
    issue(1, ROL, 32'h80000001, 32'd1);
    wait_done(1, bn, lat, ov);
    vectors++; if (lat !== 2) begin errors++; $display("FAIL rol_latency: got %0d want 2", lat); end
    vectors++; if (res1 !== 32'h00000003) begin errors++; $display("FAIL rol_result: got %h want 00000003", res1); end
    vectors++; if (cout1 !== 1'b1) begin errors++; $display("FAIL rol_cout: got %b want 1", cout1); end
    tick();
  endtask

  task automatic test_zero_and_pass();
    int bn, lat, ov;
    issue(1, SHL, 32'h12345678, 32'h00000020);
    wait_done(1, bn, lat, ov);
    vectors++; if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", lat); end
    vectors++; if (bn !== 0) begin errors++; $display("FAIL zero_busy: got %0d want 0", bn); end
    vectors++; if (res1 !== 32'h12345678) begin errors++; $display("FAIL zero_result: got %h want 12345678", res1); end
    vectors++; if (cout1 !== 1'b0) begin errors++; $display("FAIL zero_cout: got %b want 0", cout1); end
    tick();
    // Set cout to 1 first so the pass-through clearing of cout is visible.
    issue(1, ROL, 32'h80000000, 32'd1);
    wait_done(1, bn, lat, ov);
    tick();
    issue(1, PASS, 32'h12345678, 32'h00000020);
    wait_done(1, bn, lat, ov);
    vectors++; if (lat !== 1) begin errors++; $display("FAIL pass_latency: got %0d want 1", lat); end
    vectors++; if (bn !== 0) begin errors++; $display("FAIL pass_busy: got %0d want 0", bn); end
    vectors++; if (res1 !== 32'h12345678) begin errors++; $display("FAIL pass_result: got %h want 12345678", res1); end
    vectors++; if (cout1 !== 1'b0) begin errors++; $display("FAIL pass_cout: got %b want 0", cout1); end
    tick();
  endtask

  task automatic test_ignore_start();
    int bn, lat, ov;
    issue(1, SHL, 32'h00000001, 32'd20);  // now observing cycle 1
    tick(); tick(); tick();                // cycle 4
    start1 = 1'b1; mode = ROR; a = 32'hFFFFFFFF; b = 32'd3;
    tick();                                // edge 5 samples start in SHIFT
    start1 = 1'b0;
    wait_done(1, bn, lat, ov);             // i=1 is cycle 5; done at cycle 21
    vectors++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency: got %0d want 17", lat); end
    vectors++; if (res1 !== 32'h00100000) begin errors++; $display("FAIL ignore_result: got %h want 00100000", res1); end
    vectors++; if (cout1 !== 1'b0) begin errors++; $display("FAIL ignore_cout: got %b want 0", cout1); end
    tick();
    vectors++; if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL ignore_no_queue: got %b want 00", {busy1, done1}); end
  endtask

  task automatic test_clear_abort();
    int pulses;
    issue(1, SHL, 32'h00000003, 32'd20);
    for (int i = 0; i < 9; i++) tick();    // cycle 10
    vectors++; if (busy1 !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy1); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy1); end
    vectors++; if (res1 !== 32'h0) begin errors++; $display("FAIL abort_result: got %h want 00000000", res1); end
    vectors++; if ({done1, cout1} !== 2'b00) begin errors++; $display("FAIL abort_flags: got %b want 00", {done1, cout1}); end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done1) pulses++;
      tick();
    end
    vectors++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    mode = SHL; a = 32'h1; b = 32'd1; start1 = 1'b1;
    tick();                                // E0, cycle 1
    a = 32'h2;
    vectors++; if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL b2b_c1: got %b want 10", {busy1, done1}); end
    tick();                                // cycle 2
    vectors++; if (done1 !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", done1); end
    vectors++; if (res1 !== 32'h2) begin errors++; $display("FAIL b2b_res1: got %h want 00000002", res1); end
    tick();                                // cycle 3
    start1 = 1'b0;
    vectors++; if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL b2b_c3: got %b want 10", {busy1, done1}); end
    tick();                                // cycle 4
    vectors++; if (done1 !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", done1); end
    vectors++; if (res1 !== 32'h4) begin errors++; $display("FAIL b2b_res2: got %h want 00000004", res1); end
    tick();
    vectors++; if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b want 00", {busy1, done1}); end
  endtask

  initial begin
    clear = 1'b0; start1 = 1'b0; start4 = 1'b0;
    mode = SHL; a = '0; b = '0;
    test_reset();
    test_shl();
    test_right_step4();
    test_rotate();
    test_zero_and_pass();
    test_ignore_start();
    test_clear_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
